// File: rtl/latch_load_ctrl_if.sv
// Handshake and latch-bank signal bundle for latch_load_ctrl.
// The controller uses the slave view; the word source and latch bank use the master view.
interface latch_load_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] d;
    logic             en;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] last_q;

    modport master (
        output in_valid, in_data, q,
        input  in_ready, d, en, busy, done, err, last_q
    );

    modport slave (
        input  in_valid, in_data, q,
        output in_ready, d, en, busy, done, err, last_q
    );
endinterface

// File: rtl/latch_load_ctrl.sv
// Drives a gated-D latch bank through setup/enable/hold windows,
// then verifies the bank contents through a 2-flop synchronizer.
module latch_load_ctrl #(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    latch_load_ctrl_if.slave bus
);
    localparam int S_CYC   = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int E_CYC   = (EN_CYC    < 1) ? 1 : EN_CYC;
    localparam int H_CYC   = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;
    localparam int CHK_CYC = 2;
    localparam int MAX_SE  = (S_CYC > E_CYC) ? S_CYC : E_CYC;
    localparam int MAX_SEH = (MAX_SE > H_CYC) ? MAX_SE : H_CYC;
    localparam int MAX_CYC = (MAX_SEH > CHK_CYC) ? MAX_SEH : CHK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_HOLD,
        ST_CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] last_q_q, last_q_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;

    // Q is asynchronous to clk; it is only ever consumed after two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking so both flops sample pre-edge values and form a real 2-stage chain.
            sync1_q <= bus.q;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            d_q      <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            last_q_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            en_q     <= en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            last_q_q <= last_q_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        last_q_d = last_q_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = CNT_W'(S_CYC - 1);
                    d_d     = bus.in_data;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_ENABLE;
                    cnt_d   = CNT_W'(E_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ENABLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(H_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                    cnt_d   = CNT_W'(CHK_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (cnt_q == '0) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    err_d    = (sync2_q != d_q);
                    last_q_d = sync2_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // En is registered from the next state so it rises and falls exactly on state edges.
    assign en_d = (state_d == ST_ENABLE);

    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.d        = d_q;
    assign bus.en       = en_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.last_q   = last_q_q;
endmodule

// File: tb/tb_latch_load_ctrl.sv
// Directed bench for latch_load_ctrl: default-timing instance plus a stretched-timing instance,
// each feeding a behavioral gated-D latch bank.
module tb_latch_load_ctrl;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic stuck;
    logic [3:0] lat0, lat1;

    latch_load_ctrl_if #(.WIDTH(4)) if0 ();
    latch_load_ctrl_if #(.WIDTH(4)) if1 ();

    latch_load_ctrl #(.WIDTH(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    latch_load_ctrl #(.WIDTH(4), .SETUP_CYC(3), .EN_CYC(1), .HOLD_CYC(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_latch begin
        if (if0.en) lat0 = if0.d;
    end
    always_latch begin
        if (if1.en) lat1 = if1.d;
    end
    assign if0.q = stuck ? 4'h0 : lat0;
    assign if1.q = lat1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept w at edge 0, then scramble in_data while busy and watch 7 edges.
    task automatic write_word(input logic [3:0] w, input logic [3:0] exp_q, input logic exp_err);
        if0.in_valid = 1'b1;
        if0.in_data  = w;
        @(negedge clk);
        if0.in_valid = 1'b0;
        if0.in_data  = ~w;
        chk("busy_after_accept", 32'(if0.busy), 32'd1);
        chk("d_after_accept", 32'(if0.d), 32'(w));
        chk("en_after_accept", 32'(if0.en), 32'd0);
        if0.in_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            if (k == 6) if0.in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("en_k%0d", k), 32'(if0.en), 32'((k == 1) || (k == 2)));
            chk($sformatf("done_k%0d", k), 32'(if0.done), 32'(k == 6));
            chk($sformatf("d_k%0d", k), 32'(if0.d), 32'(w));
            if (k == 6) begin
                chk("err_done", 32'(if0.err), 32'(exp_err));
                chk("last_q_done", 32'(if0.last_q), 32'(exp_q));
                chk("ready_done", 32'(if0.in_ready), 32'd1);
            end
            if (k == 7) chk("err_after", 32'(if0.err), 32'd0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        stuck = 1'b0;
        rst_n = 1'b0;
        if0.in_valid = 1'b1;
        if0.in_data  = 4'hF;
        if1.in_valid = 1'b0;
        if1.in_data  = 4'h0;

        // Reset held 3 cycles with InValid high: nothing accepted.
        repeat (3) @(negedge clk);
        chk("rst_d", 32'(if0.d), 32'h0);
        chk("rst_en", 32'(if0.en), 32'h0);
        chk("rst_done", 32'(if0.done), 32'h0);
        chk("rst_err", 32'(if0.err), 32'h0);
        chk("rst_last_q", 32'(if0.last_q), 32'h0);
        chk("rst_ready", 32'(if0.in_ready), 32'h1);
        chk("rst_busy", 32'(if0.busy), 32'h0);
        if0.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(if0.busy), 32'h0);

        // Single write with a working latch bank.
        write_word(4'hA, 4'hA, 1'b0);

        // Readback mismatch with Q stuck at zero.
        stuck = 1'b1;
        write_word(4'h5, 4'h0, 1'b1);
        stuck = 1'b0;

        // Back-to-back: valid held high, second word taken on the edge after Done.
        if0.in_valid = 1'b1;
        if0.in_data  = 4'h3;
        @(negedge clk);
        if0.in_data = 4'hC;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 7) if0.in_valid = 1'b0;
            chk($sformatf("b2b_en_k%0d", k), 32'(if0.en),
                32'((k == 1) || (k == 2) || (k == 8) || (k == 9)));
            chk($sformatf("b2b_done_k%0d", k), 32'(if0.done), 32'((k == 6) || (k == 13)));
            chk($sformatf("b2b_d_k%0d", k), 32'(if0.d), (k < 7) ? 32'h3 : 32'hC);
            if (k == 6) begin
                chk("b2b_err1", 32'(if0.err), 32'h0);
                chk("b2b_last_q1", 32'(if0.last_q), 32'h3);
            end
            if (k == 13) begin
                chk("b2b_err2", 32'(if0.err), 32'h0);
                chk("b2b_last_q2", 32'(if0.last_q), 32'hC);
            end
        end

        // Reset asserted while En is high, between clock edges.
        if0.in_valid = 1'b1;
        if0.in_data  = 4'h6;
        @(negedge clk);
        if0.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_en_high", 32'(if0.en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(if0.en), 32'h0);
        chk("mid_rst_d", 32'(if0.d), 32'h0);
        chk("mid_rst_busy", 32'(if0.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("mid_no_done_%0d", k), 32'(if0.done), 32'h0);
        end
        write_word(4'h9, 4'h9, 1'b0);

        // Stretched timing instance: En at edge 3 for one cycle, Done after edge 8.
        if1.in_valid = 1'b1;
        if1.in_data  = 4'h7;
        @(negedge clk);
        if1.in_valid = 1'b0;
        if1.in_data  = 4'h1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("p_en_k%0d", k), 32'(if1.en), 32'(k == 3));
            chk($sformatf("p_done_k%0d", k), 32'(if1.done), 32'(k == 8));
            chk($sformatf("p_d_k%0d", k), 32'(if1.d), 32'h7);
            if (k == 8) begin
                chk("p_err", 32'(if1.err), 32'h0);
                chk("p_last_q", 32'(if1.last_q), 32'h7);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
